// File: rtl/discharge_scheduler.sv
// Run/stop sequencer + parameter scheduler for the discharge MOSFET controller; commit/classify 2 cycles after deion rise,
// cmd_ready low while the single shadow slot is full. Macro PULSE_STATS_EN enables the pulse/open/short statistics counters.
module discharge_scheduler #(
  parameter logic [15:0] BREAKDOWN_THRESHOLD_CUR = 16'd10,
  parameter logic [15:0] SHORT_WINDOW            = 16'd50,
  parameter logic [7:0]  MAX_CONSEC_SHORT        = 8'd8,
  parameter logic [15:0] DEFAULT_TON             = 16'd10,
  parameter logic [15:0] DEFAULT_TOFF            = 16'd20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_req,
  input  logic               stop_req,
  input  logic               clear_fault,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [15:0]        cmd_waveform,
  input  logic [15:0]        cmd_Ip,
  input  logic [15:0]        cmd_Ton,
  input  logic [15:0]        cmd_Toff,
  input  logic               mosfet_deion,
  input  logic signed [16:0] sample_current,
  output logic               is_machine,
  output logic [15:0]        waveform,
  output logic [15:0]        Ip,
  output logic [15:0]        Ton,
  output logic [15:0]        Toff,
  output logic               busy,
  output logic               fault,
  output logic [31:0]        pulse_count,
  output logic [31:0]        open_count,
  output logic [31:0]        short_count
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING, FAULT} state_t;
  state_t state;

  logic               deion_s, deion_d;
  logic signed [16:0] cur_s;
  logic [15:0]        active_timer;
  logic               cond, early;
  logic [7:0]         consec_short;
  logic               slot_full;
  logic [15:0]        slot_waveform, slot_ip, slot_ton, slot_toff;

  logic       active, rise, classify, is_short, is_open, trip, commit, take, conducting;
  logic [7:0] streak_inc;

  // Deion and current are registered first, so the whole classification sees one consistent delayed image.
  assign active     = (state == RUN) || (state == STOPPING);
  assign rise       = deion_s & ~deion_d;
  assign classify   = active & rise & (active_timer != 16'd0);
  assign conducting = cur_s >= $signed({1'b0, BREAKDOWN_THRESHOLD_CUR});
  assign is_short   = classify & early;
  assign is_open    = classify & ~cond;
  assign streak_inc = (consec_short == 8'hFF) ? 8'hFF : consec_short + 8'd1;
  assign trip       = is_short & (streak_inc >= MAX_CONSEC_SHORT);
  assign commit     = slot_full & (active ? rise : 1'b1);
  assign take       = cmd_valid & ~slot_full;
  assign cmd_ready  = ~slot_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      is_machine   <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      consec_short <= 8'd0;
    end else begin
      if (is_short)      consec_short <= streak_inc;
      else if (classify) consec_short <= 8'd0;
      case (state)
        IDLE: begin
          if (start_req && !stop_req) begin
            state      <= RUN;
            is_machine <= 1'b1;
            busy       <= 1'b1;
          end
        end
        RUN, STOPPING: begin
          if (trip) begin
            state      <= FAULT;
            is_machine <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b1;
          end else if (state == RUN) begin
            if (stop_req) state <= STOPPING;
          end else if (deion_s) begin
            // Either already in the deion interval on entry, or the closing rise of the last pulse.
            state      <= IDLE;
            is_machine <= 1'b0;
            busy       <= 1'b0;
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state        <= IDLE;
            fault        <= 1'b0;
            consec_short <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deion_s       <= 1'b1;
      deion_d       <= 1'b1;
      cur_s         <= '0;
      active_timer  <= 16'd0;
      cond          <= 1'b0;
      early         <= 1'b0;
      slot_full     <= 1'b0;
      slot_waveform <= 16'd0;
      slot_ip       <= 16'd0;
      slot_ton      <= 16'd0;
      slot_toff     <= 16'd0;
      waveform      <= 16'h0001;
      Ip            <= 16'd0;
      Ton           <= DEFAULT_TON;
      Toff          <= DEFAULT_TOFF;
    end else begin
      deion_s <= mosfet_deion;
      deion_d <= deion_s;
      cur_s   <= sample_current;

      if (!active || deion_s)           active_timer <= 16'd0;
      else if (active_timer != 16'hFFFF) active_timer <= active_timer + 16'd1;

      if (!active || rise) begin
        cond  <= 1'b0;
        early <= 1'b0;
      end else if (!deion_s && conducting) begin
        cond <= 1'b1;
        if (active_timer < SHORT_WINDOW) early <= 1'b1;
      end

      if (commit) begin
        waveform <= slot_waveform;
        Ip       <= slot_ip;
        Ton      <= slot_ton;
        Toff     <= slot_toff;
      end
      if (take) begin
        slot_waveform <= cmd_waveform;
        slot_ip       <= cmd_Ip;
        slot_ton      <= cmd_Ton;
        slot_toff     <= cmd_Toff;
      end
      slot_full <= take | (slot_full & ~commit);
    end
  end

`ifdef PULSE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_count <= 32'd0;
      open_count  <= 32'd0;
      short_count <= 32'd0;
    end else begin
      if (classify && pulse_count != 32'hFFFF_FFFF) pulse_count <= pulse_count + 32'd1;
      if (is_open  && open_count  != 32'hFFFF_FFFF) open_count  <= open_count + 32'd1;
      if (is_short && short_count != 32'hFFFF_FFFF) short_count <= short_count + 32'd1;
    end
  end
`else
  assign pulse_count = 32'd0;
  assign open_count  = 32'd0;
  assign short_count = 32'd0;
`endif
endmodule

// File: tb/tb_discharge_scheduler.sv
// Scoreboard bench for discharge_scheduler: stimulus pushes expectations from a pulse-level reference model,
// a negedge monitor pops and compares them.
module tb_discharge_scheduler;
  logic clk = 1'b0;
  logic rst_n, start_req, stop_req, clear_fault, cmd_valid, cmd_ready;
  logic [15:0] cmd_waveform, cmd_Ip, cmd_Ton, cmd_Toff;
  logic mosfet_deion;
  logic signed [16:0] sample_current;
  logic is_machine, busy, fault;
  logic [15:0] waveform, Ip, Ton, Toff;
  logic [31:0] pulse_count, open_count, short_count;

  discharge_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start_req(start_req), .stop_req(stop_req),
    .clear_fault(clear_fault), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_waveform(cmd_waveform), .cmd_Ip(cmd_Ip), .cmd_Ton(cmd_Ton), .cmd_Toff(cmd_Toff),
    .mosfet_deion(mosfet_deion), .sample_current(sample_current), .is_machine(is_machine),
    .waveform(waveform), .Ip(Ip), .Ton(Ton), .Toff(Toff), .busy(busy), .fault(fault),
    .pulse_count(pulse_count), .open_count(open_count), .short_count(short_count)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {F_ISM, F_BUSY, F_FAULT, F_RDY, F_WAVE, F_IP, F_TON, F_TOFF, F_PC, F_OC, F_SC} fld_t;
  typedef struct { int cyc; fld_t fld; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] observe(fld_t f);
    case (f)
      F_ISM:   return {31'd0, is_machine};
      F_BUSY:  return {31'd0, busy};
      F_FAULT: return {31'd0, fault};
      F_RDY:   return {31'd0, cmd_ready};
      F_WAVE:  return {16'd0, waveform};
      F_IP:    return {16'd0, Ip};
      F_TON:   return {16'd0, Ton};
      F_TOFF:  return {16'd0, Toff};
      F_PC:    return pulse_count;
      F_OC:    return open_count;
      default: return short_count;
    endcase
  endfunction

  function automatic string fname(fld_t f);
    case (f)
      F_ISM: return "is_machine";  F_BUSY: return "busy";   F_FAULT: return "fault";
      F_RDY: return "cmd_ready";   F_WAVE: return "waveform"; F_IP: return "Ip";
      F_TON: return "Ton";         F_TOFF: return "Toff";   F_PC: return "pulse_count";
      F_OC:  return "open_count";  default: return "short_count";
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        total++;
        if (sb[i].cyc < cyc || observe(sb[i].fld) !== sb[i].val) begin
          bad++;
          $display("FAIL %s cycle=%0d got=%0d expected=%0d", fname(sb[i].fld), cyc,
                   observe(sb[i].fld), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  // Reference model: run state, streak and statistics at pulse granularity.
  localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_FAULT = 3;
  int m_state, m_streak;
  int unsigned m_pc, m_oc, m_sc;
  logic [15:0] m_wave, m_ip, m_ton, m_toff;
  logic [15:0] s_wave, s_ip, s_ton, s_toff;
  bit m_slot_full;
  logic [15:0] nxt_wave, nxt_ip, nxt_ton, nxt_toff;

  task automatic exp_push(fld_t f, logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.fld = f; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_all();
    logic act;
    act = (m_state == S_RUN) || (m_state == S_STOP);
    exp_push(F_ISM, {31'd0, act});
    exp_push(F_BUSY, {31'd0, act});
    exp_push(F_FAULT, (m_state == S_FAULT) ? 32'd1 : 32'd0);
    exp_push(F_RDY, m_slot_full ? 32'd0 : 32'd1);
    exp_push(F_WAVE, {16'd0, m_wave});
    exp_push(F_IP, {16'd0, m_ip});
    exp_push(F_TON, {16'd0, m_ton});
    exp_push(F_TOFF, {16'd0, m_toff});
`ifdef PULSE_STATS_EN
    exp_push(F_PC, m_pc);
    exp_push(F_OC, m_oc);
    exp_push(F_SC, m_sc);
`else
    exp_push(F_PC, 32'd0);
    exp_push(F_OC, 32'd0);
    exp_push(F_SC, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_commit();
    if (m_slot_full) begin
      m_wave = s_wave; m_ip = s_ip; m_ton = s_ton; m_toff = s_toff;
      m_slot_full = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_streak = 0; m_pc = 0; m_oc = 0; m_sc = 0;
    m_wave = 16'h0001; m_ip = 16'd0; m_ton = 16'd10; m_toff = 16'd20;
    m_slot_full = 1'b0;
  endtask

  task automatic idle_inputs();
    start_req = 0; stop_req = 0; clear_fault = 0; cmd_valid = 0;
    cmd_waveform = 0; cmd_Ip = 0; cmd_Ton = 0; cmd_Toff = 0;
    mosfet_deion = 1; sample_current = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    exp_all();
    step(); step();
    rst_n = 1'b1;
    step();
    exp_all();
  endtask

  task automatic do_start(bit with_stop);
    start_req = 1; stop_req = with_stop;
    step();
    start_req = 0; stop_req = 0;
    if (m_state == S_IDLE && !with_stop) m_state = S_RUN;
    exp_all();
  endtask

  task automatic do_clear();
    clear_fault = 1;
    step();
    clear_fault = 0;
    if (m_state == S_FAULT) begin m_state = S_IDLE; m_streak = 0; end
    exp_all();
  endtask

  task automatic do_stop_high();
    stop_req = 1;
    step();
    stop_req = 0;
    if (m_state == S_RUN) m_state = S_STOP;
    exp_all();
    step();
    if (m_state == S_STOP) m_state = S_IDLE;
    exp_all();
  endtask

  task automatic offer_cmd();
    cmd_valid = 1;
    cmd_waveform = nxt_wave; cmd_Ip = nxt_ip; cmd_Ton = nxt_ton; cmd_Toff = nxt_toff;
  endtask

  task automatic accept_cmd();
    if (!m_slot_full) begin
      s_wave = nxt_wave; s_ip = nxt_ip; s_ton = nxt_ton; s_toff = nxt_toff;
      m_slot_full = 1'b1;
    end
  endtask

  // Parameter set offered while IDLE/FAULT: taken, then committed the following cycle.
  task automatic idle_cmd();
    offer_cmd();
    step();
    cmd_valid = 0;
    accept_cmd();
    exp_all();
    step();
    model_commit();
    exp_all();
  endtask

  // One discharge cycle: 'low' interpulse-free samples, conducting current 'cur' at sample 'idx'.
  task automatic pulse(int low, int idx, int cur, bit send, int stop_at, int high);
    bit conducted, sh;
    for (int m = 0; m < low; m++) begin
      mosfet_deion = 0;
      sample_current = (m == idx) ? 17'(cur) : 17'(int'($urandom_range(0, 19)) - 10);
      if (send && m == 1) offer_cmd();
      if (m == stop_at) stop_req = 1;
      step();
      if (cmd_valid) accept_cmd();
      if (stop_req && m_state == S_RUN) m_state = S_STOP;
      cmd_valid = 0; stop_req = 0;
    end
    exp_all();
    mosfet_deion = 1; sample_current = 0;
    step(); step();
    conducted = (idx >= 0) && (idx < low) && (cur >= 10);
    sh = conducted && (idx < 50);
    if (m_state == S_RUN || m_state == S_STOP) begin
      m_pc++;
      model_commit();
      if (sh) begin
        m_sc++; m_streak++;
        if (m_streak >= 8) m_state = S_FAULT;
      end else begin
        if (!conducted) m_oc++;
        m_streak = 0;
      end
      if (m_state == S_STOP) m_state = S_IDLE;
    end
    exp_all();
    for (int h = 2; h < high; h++) step();
  endtask

  task automatic rand_cmd();
    nxt_wave = 16'($urandom); nxt_ip = 16'($urandom);
    nxt_ton = 16'($urandom); nxt_toff = 16'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    step();
    do_reset();

    do_start(1'b1);                       // start+stop together in IDLE: stays IDLE
    nxt_wave = 16'h0003; nxt_ip = 16'd250; nxt_ton = 16'd15; nxt_toff = 16'd25;
    idle_cmd();
    do_start(1'b0);
    step();

    nxt_wave = 16'h0002; nxt_ip = 16'd100; nxt_ton = 16'd30; nxt_toff = 16'd40;
    pulse(20, -1, 0, 1'b1, -1, 3);        // open cycle carrying the Ton=30 set
    for (int k = 0; k < 5; k++) pulse(110, 100, 20, 1'b0, -1, 3);
    for (int k = 0; k < 3; k++) pulse(30, -1, 0, 1'b0, -1, 3);
    pulse(60, 49, 20, 1'b0, -1, 2);       // last short sample
    pulse(60, 50, 20, 1'b0, -1, 2);       // first normal sample
    pulse(20, 10, 9, 1'b0, -1, 2);        // just under threshold: open
    pulse(20, 10, 10, 1'b0, -1, 2);       // exactly threshold: short
    pulse(20, 10, -50, 1'b0, -1, 2);      // negative current: open
    pulse(1, 0, 20, 1'b0, -1, 2);         // one-sample short
    pulse(60, 55, 1000, 1'b0, -1, 2);     // normal clears streak

    for (int k = 0; k < 8; k++) pulse(20, 5, 20, 1'b0, -1, 3);
    do_start(1'b0);                       // ignored in FAULT
    rand_cmd();
    idle_cmd();                           // FAULT commits immediately
    do_clear();
    do_start(1'b0);

    pulse(40, 45, 20, 1'b0, 10, 3);       // stop with deion low: holds until the rise
    do_start(1'b0);
    step();
    do_stop_high();

    do_start(1'b0);
    for (int k = 0; k < 40; k++) begin
      int kind, low, idx, cur, stop_at;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        low = $urandom_range(1, 70);
        idx = $urandom_range(0, ((low < 50) ? low : 50) - 1);
        cur = $urandom_range(10, 2000);
      end else if (kind == 1) begin
        low = $urandom_range(52, 120);
        idx = $urandom_range(50, low - 1);
        cur = $urandom_range(10, 2000);
      end else begin
        low = $urandom_range(1, 80);
        idx = $urandom_range(0, low - 1);
        cur = int'($urandom_range(0, 30)) - 21;
      end
      stop_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, low - 1)) : -1;
      rand_cmd();
      pulse(low, idx, cur, 1'($urandom_range(0, 1)), stop_at, $urandom_range(2, 5));
      if (m_state == S_FAULT) do_clear();
      if (m_state == S_IDLE) do_start(1'b0);
    end

    // Reset in the middle of a pulse with a pending set: everything returns to defaults.
    mosfet_deion = 0;
    nxt_ton = 16'd77;
    offer_cmd();
    step();
    cmd_valid = 0;
    accept_cmd();
    exp_all();
    step();
    do_reset();

    repeat (4) step();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain left=%0d", sb.size());
      $fatal(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
